// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the serial boot loader and the riscv_i core.
//   ld_state_t : loader FSM states (LEN, DATA, CSUM, DONE, ERR)
//   rx_state_t : UART receiver states
//   ENTRY      : core reset vector; mem_addr word indices are relative to it
//   HDR_BYTES  : length header size in bytes
// -----------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } ld_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [31:0] ENTRY     = 32'h8000_0000;
   localparam int          HDR_BYTES = 4;

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detection,
// half-bit start re-check, mid-bit data/stop sampling.
// Ports:
//   clk, reset       : system clock, asynchronous active-low reset
//   ser_rx           : raw serial line (idle high, asynchronous)
//   rx_valid/rx_byte : one-cycle pulse with the received byte (stop bit = 1)
//   rx_ferr          : one-cycle pulse on a framing error (stop bit = 0)
//   rx_start         : one-cycle pulse when a start bit is confirmed
// CLKS_PER_BIT must be at least 4 so the half-bit count is meaningful.
// -----------------------------------------------------------------------------
module uart_rx
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ser_rx,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_ferr,
   output logic       rx_start
);

   localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             sync1_q, sync2_q, line_q;
   rx_state_t        state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [2:0]       bit_q, bit_n;
   logic [7:0]       shreg_q, shreg_n;
   logic             valid_n, ferr_n, start_n;

   always_comb begin
      // NOTE: every value written here gets its default first; a path that
      // leaves one unassigned would infer a latch.
      state_n = state_q;
      cnt_n   = cnt_q;
      bit_n   = bit_q;
      shreg_n = shreg_q;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      start_n = 1'b0;
      case (state_q)
         RX_IDLE: begin
            // True falling edge only, so a line held low after a framing
            // error does not retrigger.
            if (line_q && !sync2_q) begin
               state_n = RX_START;
               cnt_n   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_n = '0;
               bit_n = '0;
               if (sync2_q) begin
                  state_n = RX_IDLE;            // glitch, not a start bit
               end else begin
                  state_n = RX_DATA;
                  start_n = 1'b1;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n   = '0;
               shreg_n = {sync2_q, shreg_q[7:1]};  // LSB arrives first
               bit_n   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_n = RX_STOP;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               // Re-arm immediately so back-to-back frames are caught.
               state_n = RX_IDLE;
               cnt_n   = '0;
               valid_n = sync2_q;
               ferr_n  = !sync2_q;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // Synchronizer resets to the idle level so release never looks
         // like a start edge.
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         line_q   <= 1'b1;
         state_q  <= RX_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         rx_start <= 1'b0;
      end else begin
         sync1_q  <= ser_rx;
         sync2_q  <= sync1_q;
         line_q   <= sync2_q;
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         bit_q    <= bit_n;
         shreg_q  <= shreg_n;
         rx_valid <= valid_n;
         rx_ferr  <= ferr_n;
         rx_start <= start_n;
      end
   end

   assign rx_byte = shreg_q;

endmodule

// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
// Serial boot loader: receives a length-prefixed little-endian word image over
// UART, writes it sequentially into memory, then releases the core (cpu_run).
// Any protocol error parks the loader in ERR until reset.
// Ports:
//   clk, reset    : system clock, asynchronous active-low reset
//   ser_rx        : UART line (8N1, idle high)
//   mem_we        : one-cycle write strobe; mem_addr/mem_wdata valid with it
//   mem_addr      : word index relative to ENTRY
//   mem_wdata     : assembled 32-bit word
//   cpu_run       : high once the image is loaded
//   busy          : high from the first start bit until DONE or ERR
//   err           : sticky error flag
//   words_loaded  : count of words written so far
// Build option: define LOADER_CHECKSUM_EN to require a trailing 8-bit sum
// (mod 256) of all length and payload bytes.
// -----------------------------------------------------------------------------
module uart_loader
   import loader_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ser_rx,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam logic [1:0]    LAST_BYTE    = 2'(HDR_BYTES - 1);
   localparam logic [31:0]   MAX_LEN      = 32'(MAX_WORDS);
   localparam logic [ADDR_W:0] ONE_WORD   = (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
   localparam ld_state_t     AFTER_LAST   = ST_CSUM;
`else
   localparam ld_state_t     AFTER_LAST   = ST_DONE;
`endif

   logic       rx_valid, rx_ferr, rx_start;
   logic [7:0] rx_byte;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .reset    (reset),
      .ser_rx   (ser_rx),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ferr  (rx_ferr),
      .rx_start (rx_start)
   );

   ld_state_t         state_q, state_n;
   logic [1:0]        byte_cnt_q, byte_cnt_n;
   logic [31:0]       asm_q, asm_n, asm_shift;
   logic [ADDR_W:0]   len_q, len_n;
   logic [ADDR_W:0]   words_q, words_n;
   logic              mem_we_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [31:0]       mem_wdata_n;
   logic              started_q, started_n;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_n;
`endif

   always_comb begin
      state_n     = state_q;
      byte_cnt_n  = byte_cnt_q;
      asm_n       = asm_q;
      len_n       = len_q;
      words_n     = words_q;
      mem_we_n    = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      started_n   = started_q | rx_start;
`ifdef LOADER_CHECKSUM_EN
      sum_n       = sum_q;
`endif
      // Byte k of a little-endian group ends up in bits [8k+7:8k] after
      // four right shifts with the new byte entering at the top.
      asm_shift   = {rx_byte, asm_q[31:8]};

      case (state_q)
         ST_LEN: begin
            if (rx_valid) begin
               asm_n      = asm_shift;
               byte_cnt_n = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               sum_n      = sum_q + rx_byte;
`endif
               if (byte_cnt_q == LAST_BYTE) begin
                  if (asm_shift == '0) begin
                     state_n = AFTER_LAST;
                  end else if (asm_shift > MAX_LEN) begin
                     state_n = ST_ERR;
                  end else begin
                     len_n   = asm_shift[ADDR_W:0];
                     state_n = ST_DATA;
                  end
               end
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               asm_n      = asm_shift;
               byte_cnt_n = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               sum_n      = sum_q + rx_byte;
`endif
               if (byte_cnt_q == LAST_BYTE) begin
                  mem_we_n    = 1'b1;
                  mem_wdata_n = asm_shift;
                  mem_addr_n  = words_q[ADDR_W-1:0];
               end
            end
            // Count and completion follow the write strobe by one cycle.
            if (mem_we) begin
               words_n = words_q + ONE_WORD;
               if (words_q + ONE_WORD == len_q) state_n = AFTER_LAST;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (rx_valid) state_n = (rx_byte == sum_q) ? ST_DONE : ST_ERR;
         end
`endif
         default: ;  // DONE and ERR hold until reset
      endcase

      if (rx_ferr && state_q != ST_DONE) state_n = ST_ERR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_LEN;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         len_q      <= '0;
         words_q    <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         started_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_n;
         byte_cnt_q <= byte_cnt_n;
         asm_q      <= asm_n;
         len_q      <= len_n;
         words_q    <= words_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         started_q  <= started_n;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= sum_n;
`endif
      end
   end

   assign words_loaded = words_q;
   assign cpu_run      = (state_q == ST_DONE);
   assign err          = (state_q == ST_ERR);
   assign busy         = started_q &&
                         (state_q == ST_LEN || state_q == ST_DATA || state_q == ST_CSUM);

endmodule
